// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage and the external ALU.
// Contents: ALU control codes, the opcode/funct7 values decoded here,
// the issue FSM state enum, latency classes and the decoder result struct.
package alu_pkg;

    // ALU control codes, shared with the ALU instantiated by the parent
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0011;
    localparam logic [3:0] ALU_SLL     = 4'b0100;
    localparam logic [3:0] ALU_SLT     = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_MUL     = 4'b1010;
    localparam logic [3:0] ALU_DIV     = 4'b1011;
    localparam logic [3:0] ALU_DIVU    = 4'b1100;
    localparam logic [3:0] ALU_REM     = 4'b1101;
    localparam logic [3:0] ALU_REMU    = 4'b1110;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    // Opcodes handled by this stage
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct7 variants
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } issue_state_e;

    typedef enum logic [1:0] {
        LAT_SIMPLE = 2'd0,
        LAT_MUL    = 2'd1,
        LAT_DIV    = 2'd2
    } lat_class_e;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       b_imm;    // operand B comes from the immediate
        lat_class_e lat;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_issue_if.sv
// Handshake bundle of the ALU issue stage.
//   in_*  : decoded instruction offered by upstream (valid/ready)
//   out_* : captured result offered to downstream (valid/ready)
// Modports: master = upstream/downstream side, slave = the issue stage.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic [31:0] in_imm;
    logic [4:0]  in_rd;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        out_illegal;

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7,
               in_rs1_val, in_rs2_val, in_imm, in_rd, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_rd, out_illegal
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7,
               in_rs1_val, in_rs2_val, in_imm, in_rd, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Purely combinational decoder: opcode/funct3/funct7 -> ALU control code,
// operand-B select, latency class and illegal flag.
//   opcode, funct3, funct7 : instruction fields
//   dec                    : decoded control bundle
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output dec_t       dec
);

    logic [3:0] ctrl;

    always_comb begin
        ctrl = ALU_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b000:  ctrl = ALU_ADD;
                        3'b001:  ctrl = ALU_SLL;
                        3'b010:  ctrl = ALU_SLT;
                        3'b100:  ctrl = ALU_XOR;
                        3'b110:  ctrl = ALU_OR;
                        3'b111:  ctrl = ALU_AND;
                        default: ctrl = ALU_ILLEGAL;   // SLTU, SRL
                    endcase
                end else if (funct7 == F7_ALT) begin
                    // only SUB; SRA stays unsupported
                    if (funct3 == 3'b000) ctrl = ALU_SUB;
                end else if (funct7 == F7_MULDIV) begin
                    case (funct3)
                        3'b000:  ctrl = ALU_MUL;
                        3'b100:  ctrl = ALU_DIV;
                        3'b101:  ctrl = ALU_DIVU;
                        3'b110:  ctrl = ALU_REM;
                        3'b111:  ctrl = ALU_REMU;
                        default: ctrl = ALU_ILLEGAL;   // MULH*
                    endcase
                end
            end
            OP_ITYPE: begin
                case (funct3)
                    3'b000:  ctrl = ALU_ADD;
                    3'b010:  ctrl = ALU_SLT;
                    3'b100:  ctrl = ALU_XOR;
                    3'b110:  ctrl = ALU_OR;
                    3'b111:  ctrl = ALU_AND;
                    // SLLI encodes funct7 in imm[11:5]; any other pattern is malformed
                    3'b001:  ctrl = (funct7 == F7_BASE) ? ALU_SLL : ALU_ILLEGAL;
                    default: ctrl = ALU_ILLEGAL;       // SLTIU, SRLI/SRAI
                endcase
            end
            OP_BRANCH: ctrl = ALU_SUB;                 // compare by subtraction
            default:   ctrl = ALU_ILLEGAL;
        endcase

        dec.ctrl    = ctrl;
        dec.b_imm   = (opcode == OP_ITYPE);
        dec.illegal = (ctrl == ALU_ILLEGAL);
        case (ctrl)
            ALU_MUL:                             dec.lat = LAT_MUL;
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: dec.lat = LAT_DIV;
            default:                             dec.lat = LAT_SIMPLE;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts a decoded instruction, holds registered operands
// and control code on the external ALU for the op's latency, then captures
// the ALU result and offers it downstream.
//   clk, rst, flush      : clock, sync active-high reset, sync discard
//   io (slave)           : in_* instruction handshake, out_* result handshake
//   alu_a/alu_b/alu_ctrl : registered operands/control to the external ALU
//   alu_result/alu_zero  : combinational ALU outputs
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    alu_issue_if.slave  io,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    // Counter holds remaining cycles minus one, so capture happens at zero
    localparam logic [3:0] LOAD_MUL = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] LOAD_DIV = 4'(DIV_CYCLES - 1);

    issue_state_e state_reg, state_next;
    logic [3:0]   cnt_reg;
    logic [31:0]  alu_a_reg, alu_b_reg;
    logic [3:0]   alu_ctrl_reg;
    logic [4:0]   rd_reg;
    logic         illegal_reg;
    logic         out_valid_reg, out_zero_reg, out_illegal_reg;
    logic [31:0]  out_result_reg;
    logic [4:0]   out_rd_reg;

    dec_t         dec;
    logic [3:0]   lat_load;
    logic         ready_state, accept, capture;

    alu_ctrl_dec u_dec (
        .opcode (io.in_opcode),
        .funct3 (io.in_funct3),
        .funct7 (io.in_funct7),
        .dec    (dec)
    );

    always_comb begin
        case (dec.lat)
            LAT_MUL: lat_load = LOAD_MUL;
            LAT_DIV: lat_load = LOAD_DIV;
            default: lat_load = 4'd0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        ready_state = 1'b0;
        capture     = 1'b0;
        case (state_reg)
            ST_IDLE: ready_state = 1'b1;
            ST_EXEC: capture     = (cnt_reg == 4'd0) && !flush;
            ST_DONE: ready_state = io.out_ready;
            default: ready_state = 1'b0;
        endcase
        // flush wins over accept, so no handshake may complete in a flush cycle
        accept = io.in_valid && ready_state && !flush;

        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (accept) state_next = ST_EXEC;
                ST_EXEC: if (capture) state_next = ST_DONE;
                ST_DONE: if (io.out_ready) state_next = accept ? ST_EXEC : ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= 4'd0;
            alu_a_reg       <= 32'd0;
            alu_b_reg       <= 32'd0;
            alu_ctrl_reg    <= 4'd0;
            rd_reg          <= 5'd0;
            illegal_reg     <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_result_reg  <= 32'd0;
            out_zero_reg    <= 1'b0;
            out_rd_reg      <= 5'd0;
            out_illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;

            // operands only change on accept, so they stay put through EXEC
            if (accept) begin
                alu_a_reg    <= io.in_rs1_val;
                alu_b_reg    <= dec.b_imm ? io.in_imm : io.in_rs2_val;
                alu_ctrl_reg <= dec.ctrl;
                rd_reg       <= io.in_rd;
                illegal_reg  <= dec.illegal;
                cnt_reg      <= lat_load;
            end else if (state_reg == ST_EXEC && !capture && !flush) begin
                cnt_reg <= cnt_reg - 4'd1;
            end

            if (flush) begin
                out_valid_reg <= 1'b0;
            end else if (capture) begin
                out_valid_reg   <= 1'b1;
                out_result_reg  <= illegal_reg ? 32'd0 : alu_result;
                out_zero_reg    <= alu_zero;
                out_rd_reg      <= rd_reg;
                out_illegal_reg <= illegal_reg;
            end else if (state_reg == ST_DONE && io.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign io.in_ready    = ready_state && !flush;
    assign io.out_valid   = out_valid_reg;
    assign io.out_result  = out_result_reg;
    assign io.out_zero    = out_zero_reg;
    assign io.out_rd      = out_rd_reg;
    assign io.out_illegal = out_illegal_reg;
    assign alu_a          = alu_a_reg;
    assign alu_b          = alu_b_reg;
    assign alu_ctrl       = alu_ctrl_reg;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        alu_zero;

    int vectors = 0;
    int miscompares = 0;

    alu_issue_if bus ();

    alu_issue #(.MUL_CYCLES(2), .DIV_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .io         (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    // Reference ALU standing in for the one the parent instantiates
    always_comb begin
        alu_result = 32'd0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0011: alu_result = alu_a ^ alu_b;
            4'b0100: alu_result = alu_a << alu_b[4:0];
            4'b0101: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b0110: alu_result = alu_a - alu_b;
            4'b1010: alu_result = alu_a * alu_b;
            4'b1011: alu_result = (alu_b == 0) ? 32'hFFFF_FFFF : 32'($signed(alu_a) / $signed(alu_b));
            4'b1100: alu_result = (alu_b == 0) ? 32'hFFFF_FFFF : alu_a / alu_b;
            4'b1101: alu_result = (alu_b == 0) ? alu_a : 32'($signed(alu_a) % $signed(alu_b));
            4'b1110: alu_result = (alu_b == 0) ? alu_a : alu_a % alu_b;
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic        ill;
        int          edges;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [4:0] rd);
        bus.in_valid   = 1'b1;
        bus.in_opcode  = op;
        bus.in_funct3  = f3;
        bus.in_funct7  = f7;
        bus.in_rs1_val = rs1;
        bus.in_rs2_val = rs2;
        bus.in_imm     = imm;
        bus.in_rd      = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        vectors++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin miscompares++; $display("FAIL reset_alu_ab got=%h/%h exp=0/0", alu_a, alu_b); end
        vectors++; if (alu_ctrl !== 4'b0000) begin miscompares++; $display("FAIL reset_alu_ctrl got=%b exp=0000", alu_ctrl); end
        vectors++; if (bus.out_result !== 32'd0 || bus.out_rd !== 5'd0 || bus.out_zero !== 1'b0 || bus.out_illegal !== 1'b0)
            begin miscompares++; $display("FAIL reset_out_regs got=%h/%0d/%b/%b exp=0/0/0/0", bus.out_result, bus.out_rd, bus.out_zero, bus.out_illegal); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        rst = 1'b0;
        $display("txn reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
    endtask

    task automatic test_addi();
        bus.out_ready = 1'b1;
        offer(7'b0010011, 3'b000, 7'h7f, 32'd5, 32'd99, 32'hFFFF_FFFD, 5'd3);
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL addi_in_ready got=%b exp=1", bus.in_ready); end
        step();                       // accept edge
        bus.in_valid = 1'b0;
        vectors++; if (alu_ctrl !== 4'b0010 || alu_a !== 32'd5 || alu_b !== 32'hFFFF_FFFD)
            begin miscompares++; $display("FAIL addi_operands got=%b/%h/%h exp=0010/5/fffffffd", alu_ctrl, alu_a, alu_b); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL addi_early_valid got=%b exp=0", bus.out_valid); end
        step();                       // second edge: capture
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_valid got=%b exp=1", bus.out_valid); end
        vectors++; if (bus.out_result !== 32'd2 || bus.out_zero !== 1'b0 || bus.out_rd !== 5'd3 || bus.out_illegal !== 1'b0)
            begin miscompares++; $display("FAIL addi_result got=%h/%b/%0d/%b exp=2/0/3/0", bus.out_result, bus.out_zero, bus.out_rd, bus.out_illegal); end
        $display("txn addi: result=%h zero=%b rd=%0d", bus.out_result, bus.out_zero, bus.out_rd);
        step();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL addi_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_div();
        int bad = 0;
        bus.out_ready = 1'b1;
        offer(7'b0110011, 3'b100, 7'b0000001, 32'hFFFF_FFF9, 32'd2, 32'd0, 5'd9);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (alu_a !== 32'hFFFF_FFF9 || alu_b !== 32'd2 || alu_ctrl !== 4'b1011 ||
                bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
            step();
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL div_exec_hold got=%0d bad cycles exp=0", bad); end
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFFFF_FFFD || bus.out_rd !== 5'd9)
            begin miscompares++; $display("FAIL div_result got=%b/%h/%0d exp=1/fffffffd/9", bus.out_valid, bus.out_result, bus.out_rd); end
        $display("txn div: result=%h after 9 edges", bus.out_result);
        step();
    endtask

    task automatic test_beq();
        bus.out_ready = 1'b1;
        offer(7'b1100011, 3'b000, 7'h00, 32'h1234, 32'h1234, 32'h10, 5'd0);
        step();
        bus.in_valid = 1'b0;
        vectors++; if (alu_ctrl !== 4'b0110 || alu_b !== 32'h1234) begin miscompares++; $display("FAIL beq_ctrl got=%b/%h exp=0110/1234", alu_ctrl, alu_b); end
        step();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd0 || bus.out_zero !== 1'b1)
            begin miscompares++; $display("FAIL beq_result got=%b/%h/%b exp=1/0/1", bus.out_valid, bus.out_result, bus.out_zero); end
        $display("txn beq: result=%h zero=%b", bus.out_result, bus.out_zero);
        step();
    endtask

    task automatic test_sra_illegal();
        bus.out_ready = 1'b1;
        offer(7'b0110011, 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 32'd0, 5'd11);
        step();
        bus.in_valid = 1'b0;
        vectors++; if (alu_ctrl !== 4'b1111) begin miscompares++; $display("FAIL sra_ctrl got=%b exp=1111", alu_ctrl); end
        step();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_illegal !== 1'b1 || bus.out_result !== 32'd0 || bus.out_rd !== 5'd11)
            begin miscompares++; $display("FAIL sra_result got=%b/%b/%h/%0d exp=1/1/0/11", bus.out_valid, bus.out_illegal, bus.out_result, bus.out_rd); end
        $display("txn sra: illegal=%b result=%h", bus.out_illegal, bus.out_result);
        step();
    endtask

    task automatic test_opcodes();
        vec_t tbl[17];
        tbl[0]  = '{"add",  7'b0110011, 3'b000, 7'b0000000, 32'hDEADBEEF, 4'b0010, 32'd17,  1'b0, 2};
        tbl[1]  = '{"sub",  7'b0110011, 3'b000, 7'b0100000, 32'hDEADBEEF, 4'b0110, 32'd7,   1'b0, 2};
        tbl[2]  = '{"sll",  7'b0110011, 3'b001, 7'b0000000, 32'hDEADBEEF, 4'b0100, 32'd384, 1'b0, 2};
        tbl[3]  = '{"slt",  7'b0110011, 3'b010, 7'b0000000, 32'hDEADBEEF, 4'b0101, 32'd0,   1'b0, 2};
        tbl[4]  = '{"xor",  7'b0110011, 3'b100, 7'b0000000, 32'hDEADBEEF, 4'b0011, 32'd9,   1'b0, 2};
        tbl[5]  = '{"or",   7'b0110011, 3'b110, 7'b0000000, 32'hDEADBEEF, 4'b0001, 32'd13,  1'b0, 2};
        tbl[6]  = '{"and",  7'b0110011, 3'b111, 7'b0000000, 32'hDEADBEEF, 4'b0000, 32'd4,   1'b0, 2};
        tbl[7]  = '{"andi", 7'b0010011, 3'b111, 7'b0000000, 32'd10,       4'b0000, 32'd8,   1'b0, 2};
        tbl[8]  = '{"slli", 7'b0010011, 3'b001, 7'b0000000, 32'd2,        4'b0100, 32'd48,  1'b0, 2};
        tbl[9]  = '{"mul",  7'b0110011, 3'b000, 7'b0000001, 32'hDEADBEEF, 4'b1010, 32'd60,  1'b0, 3};
        tbl[10] = '{"divu", 7'b0110011, 3'b101, 7'b0000001, 32'hDEADBEEF, 4'b1100, 32'd2,   1'b0, 9};
        tbl[11] = '{"rem",  7'b0110011, 3'b110, 7'b0000001, 32'hDEADBEEF, 4'b1101, 32'd2,   1'b0, 9};
        tbl[12] = '{"remu", 7'b0110011, 3'b111, 7'b0000001, 32'hDEADBEEF, 4'b1110, 32'd2,   1'b0, 9};
        tbl[13] = '{"srl",  7'b0110011, 3'b101, 7'b0000000, 32'hDEADBEEF, 4'b1111, 32'd0,   1'b1, 2};
        tbl[14] = '{"sltu", 7'b0110011, 3'b011, 7'b0000000, 32'hDEADBEEF, 4'b1111, 32'd0,   1'b1, 2};
        tbl[15] = '{"lui",  7'b0110111, 3'b000, 7'b0000000, 32'hDEADBEEF, 4'b1111, 32'd0,   1'b1, 2};
        tbl[16] = '{"mulh", 7'b0110011, 3'b001, 7'b0000001, 32'hDEADBEEF, 4'b1111, 32'd0,   1'b1, 2};
        bus.out_ready = 1'b1;
        for (int v = 0; v < 17; v++) begin
            int edges;
            offer(tbl[v].op, tbl[v].f3, tbl[v].f7, 32'd12, 32'd5, tbl[v].imm, 5'(v + 1));
            step();
            bus.in_valid = 1'b0;
            edges = 1;
            vectors++; if (alu_ctrl !== tbl[v].ctrl) begin miscompares++; $display("FAIL %s_ctrl got=%b exp=%b", tbl[v].name, alu_ctrl, tbl[v].ctrl); end
            while (bus.out_valid !== 1'b1 && edges < 20) begin
                step();
                edges++;
            end
            vectors++; if (edges != tbl[v].edges) begin miscompares++; $display("FAIL %s_latency got=%0d exp=%0d", tbl[v].name, edges, tbl[v].edges); end
            vectors++; if (bus.out_result !== tbl[v].res || bus.out_illegal !== tbl[v].ill || bus.out_rd !== 5'(v + 1))
                begin miscompares++; $display("FAIL %s_result got=%h/%b/%0d exp=%h/%b/%0d", tbl[v].name, bus.out_result, bus.out_illegal, bus.out_rd, tbl[v].res, tbl[v].ill, v + 1); end
            $display("txn %s: ctrl=%b result=%h illegal=%b edges=%0d", tbl[v].name, alu_ctrl, bus.out_result, bus.out_illegal, edges);
            step();
        end
    endtask

    task automatic test_flush();
        int rose = 0;
        bus.out_ready = 1'b1;
        offer(7'b0110011, 3'b000, 7'b0000001, 32'd6, 32'd7, 32'd0, 5'd20);
        step();                       // accept; first EXEC cycle
        bus.in_valid = 1'b0;
        step();                       // second EXEC cycle
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got=%b exp=0", bus.out_valid); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.out_valid !== 1'b0) rose++;
        end
        vectors++; if (rose != 0) begin miscompares++; $display("FAIL flush_late_valid got=%0d exp=0", rose); end
        // flush beats a simultaneous offer: nothing is accepted
        offer(7'b0110011, 3'b100, 7'b0000000, 32'd1, 32'd2, 32'd0, 5'd21);
        flush = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_blocks_ready got=%b exp=0", bus.in_ready); end
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        step();
        step();
        vectors++; if (bus.out_valid !== 1'b0 || alu_ctrl !== 4'b1010) begin miscompares++; $display("FAIL flush_no_accept got=%b/%b exp=0/1010", bus.out_valid, alu_ctrl); end
        $display("txn flush: out_valid=%b in_ready=%b", bus.out_valid, bus.in_ready);
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        bus.out_ready = 1'b0;
        offer(7'b0110011, 3'b000, 7'b0000000, 32'd12, 32'd5, 32'd0, 5'd7);
        step();
        offer(7'b0110011, 3'b100, 7'b0000000, 32'd12, 32'd5, 32'd0, 5'd8);
        step();
        for (int i = 0; i < 3; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd17 || bus.out_rd !== 5'd7 ||
                bus.in_ready !== 1'b0 || alu_ctrl !== 4'b0010) bad++;
            step();
        end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL b2b_hold got=%0d bad cycles exp=0", bad); end
        vectors++; if (bus.out_result !== 32'd17 || bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_first got=%b/%h exp=1/11", bus.out_valid, bus.out_result); end
        $display("txn b2b first: result=%h rd=%0d", bus.out_result, bus.out_rd);
        bus.out_ready = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready got=%b exp=1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0 || alu_ctrl !== 4'b0011) begin miscompares++; $display("FAIL b2b_accept got=%b/%b exp=0/0011", bus.out_valid, alu_ctrl); end
        step();
        vectors++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd9 || bus.out_rd !== 5'd8)
            begin miscompares++; $display("FAIL b2b_second got=%b/%h/%0d exp=1/9/8", bus.out_valid, bus.out_result, bus.out_rd); end
        $display("txn b2b second: result=%h rd=%0d", bus.out_result, bus.out_rd);
        step();
    endtask

    task automatic test_reset_midop();
        bus.out_ready = 1'b1;
        offer(7'b0110011, 3'b100, 7'b0000001, 32'd100, 32'd7, 32'd0, 5'd30);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        flush = 1'b1;
        step();
        rst = 1'b0;
        flush = 1'b0;
        #1;
        vectors++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_ctrl !== 4'b0000)
            begin miscompares++; $display("FAIL midrst_alu got=%h/%h/%b exp=0/0/0000", alu_a, alu_b, alu_ctrl); end
        vectors++; if (bus.out_valid !== 1'b0 || bus.out_result !== 32'd0 || bus.out_rd !== 5'd0 || bus.out_zero !== 1'b0)
            begin miscompares++; $display("FAIL midrst_out got=%b/%h/%0d/%b exp=0/0/0/0", bus.out_valid, bus.out_result, bus.out_rd, bus.out_zero); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
        $display("txn midop reset: in_ready=%b out_valid=%b", bus.in_ready, bus.out_valid);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_opcode  = 7'd0;
        bus.in_funct3  = 3'd0;
        bus.in_funct7  = 7'd0;
        bus.in_rs1_val = 32'd0;
        bus.in_rs2_val = 32'd0;
        bus.in_imm     = 32'd0;
        bus.in_rd      = 5'd0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_addi();
        test_div();
        test_beq();
        test_sra_illegal();
        test_opcodes();
        test_flush();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
